rand_range: RTL and testbench

Bounded random-number drawer between the 8-bit LFSR and the game logic (spawn positions, enemy choices). On request it advances the LFSR and samples its byte. It reduces the byte to the range 0..LIMIT-1 by rejection sampling, with a guaranteed-termination fallback. It then holds the result under a valid/ack handshake until the consumer takes it.

---
 rtl/rand_range_if.sv | 31 +++
 rtl/rand_range.sv | 114 +++++++++++
 tb/tb_rand_range.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rand_range_if.sv
// LFSR sampling and valid/ack result handshake bundle for rand_range.
// master: consumer plus LFSR source; slave: the drawer.
interface rand_range_if;
  logic [7:0] lfsr_out;
  logic       lfsr_en;
  logic       req;
  logic       busy;
  logic       valid;
  logic [7:0] value;
  logic       ack;

  modport master (
    output lfsr_out,
    output req,
    output ack,
    input  lfsr_en,
    input  busy,
    input  valid,
    input  value
  );

  modport slave (
    input  lfsr_out,
    input  req,
    input  ack,
    output lfsr_en,
    output busy,
    output valid,
    output value
  );
endinterface

// File: rtl/rand_range.sv
// Bounded random draw 0..LIMIT-1 from an 8-bit LFSR by rejection sampling with fallback.
// Optional macro RNG_STIR_EN keeps the LFSR free-running in every state.
module rand_range #(
  parameter int unsigned LIMIT     = 10,
  parameter int unsigned MAX_TRIES = 4
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  rand_range_if.slave  io_bus
);

  // Smallest 2^k-1 covering LIMIT-1.
  function automatic int unsigned calc_mask(input int unsigned lim);
    int unsigned m;
    m = 0;
    for (int k = 0; k < 8; k++) begin
      if (m < lim - 1) m = (m << 1) | 1;
    end
    return m;
  endfunction

  localparam logic [7:0] MASK     = 8'(calc_mask(LIMIT));
  localparam logic [8:0] LIMIT_W  = 9'(LIMIT);
  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  typedef enum logic [1:0] {StIdle, StDraw, StHold} state_e;

  state_e     r_state;
  logic [3:0] r_tries;
  logic       r_valid;
  logic [7:0] r_value;

  state_e     w_state_d;
  logic [3:0] w_tries_d;
  logic       w_valid_d;
  logic [7:0] w_value_d;

  logic [7:0] w_masked;
  logic       w_in_range;
  logic [7:0] w_fallback;

  assign w_masked   = io_bus.lfsr_out & MASK;
  assign w_in_range = ({1'b0, w_masked} < LIMIT_W);
  // Masking guarantees masked-LIMIT < LIMIT whenever masked is out of range.
  assign w_fallback = w_masked - LIMIT_W[7:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
      r_tries <= 4'd0;
      r_valid <= 1'b0;
      r_value <= 8'h00;
    end else begin
      r_state <= w_state_d;
      r_tries <= w_tries_d;
      r_valid <= w_valid_d;
      r_value <= w_value_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_tries_d = r_tries;
    w_valid_d = r_valid;
    w_value_d = r_value;
    unique case (r_state)
      StIdle: begin
        if (io_bus.req) begin
          w_state_d = StDraw;
          w_tries_d = 4'd0;
        end
      end
      StDraw: begin
        if (w_in_range) begin
          w_value_d = w_masked;
          w_valid_d = 1'b1;
          w_state_d = StHold;
        end else if (r_tries == LAST_TRY) begin
          w_value_d = w_fallback;
          w_valid_d = 1'b1;
          w_state_d = StHold;
        end else begin
          w_tries_d = r_tries + 4'd1;
        end
      end
      StHold: begin
        if (io_bus.ack) begin
          w_valid_d = 1'b0;
          if (io_bus.req) begin
            w_state_d = StDraw;
            w_tries_d = 4'd0;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_valid_d = 1'b0;
      end
    endcase
  end

  assign io_bus.busy  = (r_state == StDraw);
  assign io_bus.valid = r_valid;
  assign io_bus.value = r_value;

`ifdef RNG_STIR_EN
  assign io_bus.lfsr_en = 1'b1;
`else
  assign io_bus.lfsr_en = (r_state == StDraw);
`endif

endmodule

// File: tb/tb_rand_range.sv
// Self-checking bench for rand_range: LIMIT=10 main instance plus LIMIT=256 and LIMIT=1 extremes.
// LFSR bytes are fed from a queue, one per DRAW cycle; expected results go through a scoreboard.
module tb_rand_range;

`ifdef RNG_STIR_EN
  localparam bit Stir = 1'b1;
`else
  localparam bit Stir = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] lfsr_bytes[$];
  logic [7:0] sb[$];
  logic [7:0] lfsr10 = 8'h00;
  logic [7:0] lfsr256 = 8'h00;
  logic [7:0] lfsr1 = 8'h00;

  rand_range_if bus10 ();
  rand_range_if bus256 ();
  rand_range_if bus1 ();

  assign bus10.lfsr_out  = lfsr10;
  assign bus256.lfsr_out = lfsr256;
  assign bus1.lfsr_out   = lfsr1;

  rand_range #(.LIMIT(10), .MAX_TRIES(4)) dut10 (
    .i_clk(clk), .i_reset_n(reset_n), .io_bus(bus10.slave));
  rand_range #(.LIMIT(256), .MAX_TRIES(4)) dut256 (
    .i_clk(clk), .i_reset_n(reset_n), .io_bus(bus256.slave));
  rand_range #(.LIMIT(1), .MAX_TRIES(4)) dut1 (
    .i_clk(clk), .i_reset_n(reset_n), .io_bus(bus1.slave));

  always #5 clk = ~clk;

  // Present the next queued byte for each DRAW cycle; the last byte is held once the queue drains.
  always @(posedge clk) begin
    #1;
    if (bus10.busy === 1'b1 && lfsr_bytes.size() > 0) lfsr10 = lfsr_bytes.pop_front();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_accept();
    logic [7:0] exp;
    bit stable;
    lfsr_bytes.delete();
    lfsr_bytes.push_back(8'h37);
    sb.push_back(8'h07);
    bus10.req = 1'b1;
    step();
    bus10.req = 1'b0;
    checks++;
    if (bus10.busy !== 1'b1 || bus10.lfsr_en !== 1'b1 || bus10.valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_draw: busy=%b en=%b valid=%b, want 1 1 0",
               bus10.busy, bus10.lfsr_en, bus10.valid);
    end
    step();
    exp = sb.pop_front();
    checks++;
    if (bus10.valid !== 1'b1 || bus10.value !== exp) begin
      errors++;
      $display("FAIL accept_result: valid=%b value=%h, want 1 %h", bus10.valid, bus10.value, exp);
    end
    checks++;
    if (bus10.busy !== 1'b0 || bus10.lfsr_en !== Stir) begin
      errors++;
      $display("FAIL accept_en_drop: busy=%b en=%b, want 0 %b", bus10.busy, bus10.lfsr_en, Stir);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus10.valid !== 1'b1 || bus10.value !== exp || bus10.busy !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL accept_hold: value=%h valid=%b, want %h 1 throughout",
               bus10.value, bus10.valid, exp);
    end
    bus10.ack = 1'b1;
    step();
    bus10.ack = 1'b0;
    checks++;
    if (bus10.valid !== 1'b0 || bus10.value !== exp || bus10.busy !== 1'b0) begin
      errors++;
      $display("FAIL accept_ack: valid=%b value=%h busy=%b, want 0 %h 0",
               bus10.valid, bus10.value, bus10.busy, exp);
    end
  endtask

  task automatic test_reset();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus10.valid !== 1'b0 || bus10.value !== 8'h00 || bus10.busy !== 1'b0 ||
        bus10.lfsr_en !== Stir) begin
      errors++;
      $display("FAIL reset_async: valid=%b value=%h busy=%b en=%b, want 0 00 0 %b",
               bus10.valid, bus10.value, bus10.busy, bus10.lfsr_en, Stir);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (bus10.valid !== 1'b0 || bus10.value !== 8'h00 || bus10.busy !== 1'b0 ||
        bus10.lfsr_en !== Stir) begin
      errors++;
      $display("FAIL reset_idle: valid=%b value=%h busy=%b en=%b, want 0 00 0 %b",
               bus10.valid, bus10.value, bus10.busy, bus10.lfsr_en, Stir);
    end
  endtask

  task automatic test_rejection();
    logic [7:0] exp;
    int n;
    bit both;
    lfsr_bytes.delete();
    lfsr_bytes.push_back(8'h0C);
    lfsr_bytes.push_back(8'h0F);
    lfsr_bytes.push_back(8'h03);
    sb.push_back(8'h03);
    bus10.req = 1'b1;
    step();
    bus10.req = 1'b0;
    n = 0;
    both = 1'b0;
    while (bus10.valid !== 1'b1 && n < 12) begin
      step();
      n++;
      if (bus10.busy === 1'b1 && bus10.valid === 1'b1) both = 1'b1;
    end
    exp = sb.pop_front();
    checks++;
    if (n != 3 || both) begin
      errors++;
      $display("FAIL reject_latency: edges=%0d overlap=%b, want 3 0", n, both);
    end
    checks++;
    if (bus10.valid !== 1'b1 || bus10.value !== exp) begin
      errors++;
      $display("FAIL reject_value: valid=%b value=%h, want 1 %h", bus10.valid, bus10.value, exp);
    end
    bus10.ack = 1'b1;
    step();
    bus10.ack = 1'b0;
  endtask

  task automatic test_fallback();
    logic [7:0] exp;
    int n;
    int draws;
    lfsr_bytes.delete();
    lfsr_bytes.push_back(8'h0E);
    sb.push_back(8'h04);
    bus10.req = 1'b1;
    step();
    bus10.req = 1'b0;
    draws = (bus10.busy === 1'b1) ? 1 : 0;
    n = 0;
    while (bus10.valid !== 1'b1 && n < 20) begin
      step();
      n++;
      if (bus10.busy === 1'b1) draws++;
    end
    exp = sb.pop_front();
    checks++;
    if (draws != 4) begin
      errors++;
      $display("FAIL fallback_cycles: draw cycles=%0d, want 4", draws);
    end
    checks++;
    if (bus10.valid !== 1'b1 || bus10.value !== exp) begin
      errors++;
      $display("FAIL fallback_value: valid=%b value=%h, want 1 %h", bus10.valid, bus10.value, exp);
    end
  endtask

  // Entered with the fallback result still held.
  task automatic test_handshake();
    logic [7:0] exp;
    bit quiet;
    bus10.ack = 1'b1;
    step();
    checks++;
    if (bus10.valid !== 1'b0 || bus10.busy !== 1'b0) begin
      errors++;
      $display("FAIL hs_ack_idle: valid=%b busy=%b, want 0 0", bus10.valid, bus10.busy);
    end
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus10.valid !== 1'b0 || bus10.busy !== 1'b0) quiet = 1'b0;
    end
    bus10.ack = 1'b0;
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL hs_ack_ignored: valid=%b busy=%b, want 0 0", bus10.valid, bus10.busy);
    end
    lfsr_bytes.delete();
    lfsr_bytes.push_back(8'h05);
    sb.push_back(8'h05);
    bus10.req = 1'b1;
    step();
    bus10.req = 1'b0;
    step();
    exp = sb.pop_front();
    checks++;
    if (bus10.valid !== 1'b1 || bus10.value !== exp) begin
      errors++;
      $display("FAIL hs_first: valid=%b value=%h, want 1 %h", bus10.valid, bus10.value, exp);
    end
    lfsr_bytes.push_back(8'h09);
    sb.push_back(8'h09);
    bus10.ack = 1'b1;
    bus10.req = 1'b1;
    step();
    bus10.ack = 1'b0;
    bus10.req = 1'b0;
    checks++;
    if (bus10.valid !== 1'b0 || bus10.busy !== 1'b1) begin
      errors++;
      $display("FAIL hs_b2b_draw: valid=%b busy=%b, want 0 1", bus10.valid, bus10.busy);
    end
    step();
    exp = sb.pop_front();
    checks++;
    if (bus10.valid !== 1'b1 || bus10.value !== exp) begin
      errors++;
      $display("FAIL hs_b2b_result: valid=%b value=%h, want 1 %h", bus10.valid, bus10.value, exp);
    end
    bus10.ack = 1'b1;
    step();
    bus10.ack = 1'b0;
  endtask

  task automatic test_mid_draw_reset();
    logic [7:0] exp;
    lfsr_bytes.delete();
    lfsr_bytes.push_back(8'h0C);
    bus10.req = 1'b1;
    step();
    bus10.req = 1'b0;
    step();
    checks++;
    if (bus10.busy !== 1'b1 || dut10.r_tries !== 4'd1) begin
      errors++;
      $display("FAIL mid_pre: busy=%b tries=%0d, want 1 1", bus10.busy, dut10.r_tries);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus10.busy !== 1'b0 || bus10.valid !== 1'b0 || bus10.value !== 8'h00 ||
        dut10.r_tries !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b valid=%b value=%h tries=%0d, want 0 0 00 0",
               bus10.busy, bus10.valid, bus10.value, dut10.r_tries);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    step();
    lfsr_bytes.delete();
    lfsr_bytes.push_back(8'h05);
    sb.push_back(8'h05);
    bus10.req = 1'b1;
    step();
    bus10.req = 1'b0;
    step();
    exp = sb.pop_front();
    checks++;
    if (bus10.valid !== 1'b1 || bus10.value !== exp) begin
      errors++;
      $display("FAIL mid_redraw: valid=%b value=%h, want 1 %h", bus10.valid, bus10.value, exp);
    end
    bus10.ack = 1'b1;
    step();
    bus10.ack = 1'b0;
  endtask

  task automatic test_extremes();
    lfsr256 = 8'hFF;
    lfsr1 = 8'hA7;
    bus256.req = 1'b1;
    bus1.req = 1'b1;
    step();
    bus256.req = 1'b0;
    bus1.req = 1'b0;
    step();
    checks++;
    if (bus256.valid !== 1'b1 || bus256.value !== 8'hFF) begin
      errors++;
      $display("FAIL limit256: valid=%b value=%h, want 1 ff", bus256.valid, bus256.value);
    end
    checks++;
    if (bus1.valid !== 1'b1 || bus1.value !== 8'h00) begin
      errors++;
      $display("FAIL limit1: valid=%b value=%h, want 1 00", bus1.valid, bus1.value);
    end
    checks++;
    if (bus1.lfsr_en !== Stir || bus256.lfsr_en !== Stir) begin
      errors++;
      $display("FAIL extremes_en: en1=%b en256=%b, want %b", bus1.lfsr_en, bus256.lfsr_en, Stir);
    end
    bus256.ack = 1'b1;
    bus1.ack = 1'b1;
    step();
    bus256.ack = 1'b0;
    bus1.ack = 1'b0;
  endtask

  initial begin
    bus10.req = 1'b0;
    bus10.ack = 1'b0;
    bus256.req = 1'b0;
    bus256.ack = 1'b0;
    bus1.req = 1'b0;
    bus1.ack = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    test_accept();
    test_reset();
    test_rejection();
    test_fallback();
    test_handshake();
    test_mid_draw_reset();
    test_extremes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
